// File: rtl/rv_pkg.sv
// Shared RV32I definitions: opcode constants, the NOP encoding and the fetch FSM states.
package rv_pkg;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_S      = 7'b0100011;
   localparam logic [6:0] OPC_B      = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

   // ECALL and EBREAK share the SYSTEM opcode; either one stops fetch.
   function automatic logic is_system(input logic [6:0] opcode);
      return (opcode == OPC_SYSTEM);
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: instruction-memory port, decode handshake and redirect/halt signals.
interface instr_fetch_if #(parameter int XLEN = 32);

   logic            IMemReq;
   logic [XLEN-1:0] IMemAddr;
   logic [31:0]     IMemData;
   logic            InstValid;
   logic            InstReady;
   logic [31:0]     Inst;
   logic [XLEN-1:0] PC;
   logic [XLEN-1:0] PCPlus4;
   logic [6:0]      Opcode;
   logic [2:0]      Function3;
   logic [6:0]      Function7;
   logic [4:0]      Rs1;
   logic [4:0]      Rs2;
   logic [4:0]      Rd;
   logic            NextPCSrc;
   logic [XLEN-1:0] BrTarget;
   logic            Halted;

   modport master (
      output IMemReq, IMemAddr, InstValid, Inst, PC, PCPlus4,
             Opcode, Function3, Function7, Rs1, Rs2, Rd, Halted,
      input  IMemData, InstReady, NextPCSrc, BrTarget
   );

   modport slave (
      input  IMemReq, IMemAddr, InstValid, Inst, PC, PCPlus4,
             Opcode, Function3, Function7, Rs1, Rs2, Rd, Halted,
      output IMemData, InstReady, NextPCSrc, BrTarget
   );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry {PC, instruction} buffer between instruction memory and decode.
module fetch_fifo
   import rv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   input  logic            flush,
   input  logic [XLEN-1:0] push_pc,
   input  logic [31:0]     push_inst,
   output logic [XLEN-1:0] head_pc,
   output logic [31:0]     head_inst,
   output logic [1:0]      count
);

   logic [1:0][XLEN-1:0] pc_q, pc_d;
   logic [1:0][31:0]     inst_q, inst_d;
   logic                 rd_ptr_q, rd_ptr_d;
   logic                 wr_ptr_q, wr_ptr_d;
   logic [1:0]           count_q, count_d;

   // Next-state: flush wins; push and pop may coincide even when full.
   always_comb begin
      pc_d     = pc_q;
      inst_d   = inst_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push) begin
            pc_d[wr_ptr_q]   = push_pc;
            inst_d[wr_ptr_q] = push_inst;
            wr_ptr_d         = ~wr_ptr_q;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         count_d = count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // Buffer storage and pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= {(2*XLEN){1'b0}};
         inst_q   <= {64{1'b0}};
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         pc_q     <= pc_d;
         inst_q   <= inst_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_pc   = pc_q[rd_ptr_q];
   assign head_inst = inst_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch stage: owns the PC, keeps at most two words buffered or in flight,
// hands them to decode over valid/ready, follows redirects and stops on ECALL/EBREAK.
module instr_fetch
   import rv_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
   input  logic          clk,
   input  logic          rst,
   instr_fetch_if.master bus
);

   localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(4);
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic            inflight_q, inflight_d;
   logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

   logic [XLEN-1:0] head_pc_s;
   logic [31:0]     head_inst_s;
   logic [1:0]      fifo_count_s;
   logic            inst_valid_s, accept_s, halt_s, redirect_s;
   logic            push_s, flush_s, req_s;
   logic [XLEN-1:0] req_addr_s, pc_s;
   logic [31:0]     inst_s;
   logic [2:0]      occupancy_s;

   fetch_fifo #(.XLEN(XLEN)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s),
      .pop       (accept_s),
      .flush     (flush_s),
      .push_pc   (inflight_pc_q),
      .push_inst (bus.IMemData),
      .head_pc   (head_pc_s),
      .head_inst (head_inst_s),
      .count     (fifo_count_s)
   );

   // Handshake decode, request issue and FSM next state; halt beats redirect.
   always_comb begin
      inst_valid_s  = (fifo_count_s != 2'd0);
      accept_s      = inst_valid_s && bus.InstReady;
      halt_s        = accept_s && is_system(head_inst_s[6:0]);
      redirect_s    = accept_s && bus.NextPCSrc && !halt_s;
      flush_s       = halt_s || redirect_s;
      push_s        = inflight_q && !flush_s;
      occupancy_s   = {1'b0, fifo_count_s} + {2'b00, inflight_q} - {2'b00, accept_s};
      state_d       = state_q;
      req_s         = 1'b0;
      req_addr_s    = fetch_pc_q;
      case (state_q)
         RUN: begin
            if (halt_s) begin
               state_d = HALT;
            end else if (redirect_s) begin
               req_s      = 1'b1;
               req_addr_s = bus.BrTarget & ALIGN_MASK;
            end else if (occupancy_s < 3'd2) begin
               req_s = 1'b1;
            end else begin
               req_s = 1'b0;
            end
         end
         HALT:    state_d = HALT;
         default: state_d = RUN;
      endcase
      fetch_pc_d    = req_s ? (req_addr_s + WORD_BYTES) : fetch_pc_q;
      inflight_d    = req_s;
      inflight_pc_d = req_s ? req_addr_s : inflight_pc_q;
   end

   // FSM state, fetch PC and outstanding-request tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= RUN;
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= RESET_PC;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   // With nothing buffered, PC shows the next address decode will see.
   always_comb begin
      if (inst_valid_s) begin
         pc_s   = head_pc_s;
         inst_s = head_inst_s;
      end else begin
         pc_s   = inflight_q ? inflight_pc_q : fetch_pc_q;
         inst_s = NOP_INST;
      end
   end

   assign bus.IMemReq   = req_s;
   assign bus.IMemAddr  = req_addr_s;
   assign bus.InstValid = inst_valid_s;
   assign bus.Inst      = inst_s;
   assign bus.PC        = pc_s;
   assign bus.PCPlus4   = pc_s + WORD_BYTES;
   assign bus.Opcode    = inst_s[6:0];
   assign bus.Rd        = inst_s[11:7];
   assign bus.Function3 = inst_s[14:12];
   assign bus.Rs1       = inst_s[19:15];
   assign bus.Rs2       = inst_s[24:20];
   assign bus.Function7 = inst_s[31:25];
   assign bus.Halted    = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations, then random
// ready/redirect/reset traffic checked every cycle against a queue-based model.
module tb_instr_fetch;

   localparam logic [31:0] HALT_ADDR = 32'h0000_0200;
   localparam logic [31:0] NOP       = 32'h0000_0013;

   logic clk;
   logic rst;

   instr_fetch_if #(.XLEN(32)) bus ();

   instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   // Memory image: every word holds its own address, except one SYSTEM instruction.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == HALT_ADDR) ? 32'h0000_0073 : a;
   endfunction

   always @(posedge clk) begin
      if (bus.IMemReq === 1'b1) bus.IMemData <= mem_word(bus.IMemAddr);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Reference model: every issued request is an entry {pc, issue cycle}, whether
   // still in flight or buffered; an entry is presentable two cycles after issue.
   typedef struct {
      logic [31:0] pc;
      int          t;
   } ent_t;

   ent_t        q[$];
   logic [31:0] m_next   = 32'h0;
   bit          m_halted = 1'b0;
   int          m_cyc    = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            q.delete();
            m_next   = 32'h0;
            m_halted = 1'b0;
         end else begin
            logic        e_valid, acc, halt_now, redir, e_req;
            logic [31:0] e_pc, e_inst, head_word, e_addr;
            int          sz;
            sz        = q.size();
            e_valid   = !m_halted && (sz > 0) && (m_cyc >= q[0].t + 2);
            e_pc      = (sz > 0) ? q[0].pc : m_next;
            head_word = mem_word(e_pc);
            e_inst    = e_valid ? head_word : NOP;
            acc       = e_valid && bus.InstReady;
            halt_now  = acc && (head_word[6:0] == 7'b1110011);
            redir     = acc && bus.NextPCSrc && !halt_now;
            e_req     = !m_halted && !halt_now && (redir || (sz - int'(acc) < 2));
            e_addr    = redir ? (bus.BrTarget & 32'hFFFF_FFFC) : m_next;

            chk("InstValid", {31'h0, bus.InstValid}, {31'h0, e_valid});
            chk("Halted",    {31'h0, bus.Halted},    {31'h0, m_halted});
            chk("IMemReq",   {31'h0, bus.IMemReq},   {31'h0, e_req});
            if (!m_halted) begin
               chk("PC",      bus.PC,      e_pc);
               chk("PCPlus4", bus.PCPlus4, e_pc + 32'd4);
               chk("Inst",    bus.Inst,    e_inst);
               chk("fields", {bus.Function7, bus.Rs2, bus.Rs1, bus.Function3, bus.Rd, bus.Opcode}, e_inst);
            end
            if (e_req) chk("IMemAddr", bus.IMemAddr, e_addr);

            if (acc) void'(q.pop_front());
            if (halt_now) begin
               q.delete();
               m_halted = 1'b1;
            end else if (redir) begin
               q.delete();
               q.push_back('{pc: e_addr, t: m_cyc});
               m_next = e_addr + 32'd4;
            end else if (e_req) begin
               q.push_back('{pc: m_next, t: m_cyc});
               m_next = m_next + 32'd4;
            end
         end
         m_cyc++;
      end
   end

   task automatic drive(input logic r, input logic rdy, input logic nps, input logic [31:0] tgt);
      @(posedge clk);
      #1;
      rst           = r;
      bus.InstReady = rdy;
      bus.NextPCSrc = nps;
      bus.BrTarget  = tgt;
   endtask

   initial begin
      rst           = 1'b1;
      bus.InstReady = 1'b0;
      bus.NextPCSrc = 1'b0;
      bus.BrTarget  = 32'h0;
      repeat (2) drive(1'b1, 1'b1, 1'b0, 32'h0);

      // Cycle 0 after reset: first request, nothing presented yet.
      drive(1'b0, 1'b1, 1'b0, 32'h0); @(negedge clk);
      chk("c0 IMemReq",   {31'h0, bus.IMemReq},   32'h1);
      chk("c0 IMemAddr",  bus.IMemAddr,           32'h0);
      chk("c0 InstValid", {31'h0, bus.InstValid}, 32'h0);
      chk("c0 Inst",      bus.Inst,               NOP);
      chk("c0 PC",        bus.PC,                 32'h0);
      chk("c0 PCPlus4",   bus.PCPlus4,            32'h4);
      chk("c0 Halted",    {31'h0, bus.Halted},    32'h0);
      drive(1'b0, 1'b1, 1'b0, 32'h0); @(negedge clk);
      chk("c1 InstValid", {31'h0, bus.InstValid}, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 32'h0); @(negedge clk);
      chk("c2 InstValid", {31'h0, bus.InstValid}, 32'h1);
      chk("c2 PC",        bus.PC,                 32'h0);
      drive(1'b0, 1'b1, 1'b0, 32'h0); @(negedge clk);
      chk("c3 PCPlus4",   bus.PCPlus4,            32'h8);

      // Backpressure with PC 0x8 at the head.
      repeat (3) drive(1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("stall PC",      bus.PC,               32'h8);
      chk("stall IMemReq", {31'h0, bus.IMemReq}, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 32'h0); @(negedge clk);
      chk("c7 PC", bus.PC, 32'h8);
      drive(1'b0, 1'b1, 1'b0, 32'h0); @(negedge clk);
      chk("c8 PC", bus.PC, 32'hC);

      // Redirect taken on the accept of 0x10.
      drive(1'b0, 1'b1, 1'b1, 32'h40); @(negedge clk);
      chk("c9 PC",       bus.PC,       32'h10);
      chk("c9 IMemAddr", bus.IMemAddr, 32'h40);
      drive(1'b0, 1'b1, 1'b0, 32'h0); @(negedge clk);
      chk("c10 InstValid", {31'h0, bus.InstValid}, 32'h0);
      drive(1'b0, 1'b0, 1'b1, 32'h80); @(negedge clk);
      chk("c11 PC", bus.PC, 32'h40);

      // Redirect while full, with an unaligned target.
      drive(1'b0, 1'b1, 1'b1, 32'h43); @(negedge clk);
      chk("c12 PC",       bus.PC,       32'h40);
      chk("c12 IMemAddr", bus.IMemAddr, 32'h40);
      drive(1'b0, 1'b1, 1'b0, 32'h0); @(negedge clk);
      chk("c13 InstValid", {31'h0, bus.InstValid}, 32'h0);

      // Wrap at the top of the address space.
      drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8); @(negedge clk);
      chk("c14 PC", bus.PC, 32'h40);
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 32'h0); @(negedge clk);
      chk("c16 PC", bus.PC, 32'hFFFF_FFF8);
      drive(1'b0, 1'b1, 1'b0, 32'h0); @(negedge clk);
      chk("c17 PCPlus4", bus.PCPlus4, 32'h0);

      // Jump to the SYSTEM instruction and halt.
      drive(1'b0, 1'b1, 1'b1, HALT_ADDR); @(negedge clk);
      chk("c18 PC", bus.PC, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 32'h0); @(negedge clk);
      chk("c20 Inst", bus.Inst, 32'h0000_0073);
      drive(1'b0, 1'b1, 1'b0, 32'h0); @(negedge clk);
      chk("c21 Halted",    {31'h0, bus.Halted},    32'h1);
      chk("c21 InstValid", {31'h0, bus.InstValid}, 32'h0);
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 1'b1, 1'b1, 32'h100); @(negedge clk);
         chk("halt IMemReq", {31'h0, bus.IMemReq}, 32'h0);
      end

      // Reset pulse restarts fetch.
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 32'h0); @(negedge clk);
      chk("restart IMemAddr", bus.IMemAddr,        32'h0);
      chk("restart Halted",   {31'h0, bus.Halted}, 32'h0);
      repeat (2) drive(1'b0, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      chk("restart PC", bus.PC, 32'h0);

      // Reset with a response outstanding: the stale word must not appear.
      repeat (5) drive(1'b0, 1'b1, 1'b0, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 32'h0); @(negedge clk);
      chk("stale InstValid", {31'h0, bus.InstValid}, 32'h0);
      drive(1'b0, 1'b1, 1'b0, 32'h0); @(negedge clk);
      chk("stale PC",   bus.PC,   32'h0);
      chk("stale Inst", bus.Inst, 32'h0);

      // Random traffic; a halt or an occasional random reset is followed by reset.
      for (int i = 0; i < 3000; i++) begin
         logic        r, rdy, nps;
         logic [31:0] tgt;
         int          sel;
         r   = m_halted || ($urandom_range(0, 199) == 0);
         rdy = ($urandom_range(0, 9) < 7);
         nps = ($urandom_range(0, 9) < 2);
         sel = $urandom_range(0, 3);
         if (sel == 0)      tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         else if (sel == 1) tgt = $urandom & 32'h0000_0FFF;
         else               tgt = $urandom;
         drive(r, rdy, nps, tgt);
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
